// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port byte/half/word access arbiter in front of data_memory (DMEM_ARB_RR_EN: round-robin)
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, HALF2, RESP} state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state, state_nxt;
  logic        sel;
  logic        accept;
  logic        reject;
  logic        s_we;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        h_port;
  logic        h_we;
  logic [31:0] h_addr;
  logic [7:0]  h_hi;
  logic [7:0]  lo_q;
  logic        resp_port;
  logic [1:0]  resp_size;
  logic [1:0]  err_q;
  logic [31:0] resp_data;

`ifdef DMEM_ARB_RR_EN
  logic        last_gnt;

  // on conflict the port that did not win last time is chosen
  always_comb begin
    sel = (p0_req && p1_req) ? !last_gnt : !p0_req;
  end

  // last-grant pointer follows every grant, rejected ones included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= sel;
    end
  end
`else
  // fixed priority: port 0 wins whenever it asks
  always_comb begin
    sel = !p0_req;
  end
`endif

  // select the winning request and classify it
  always_comb begin
    s_we    = sel ? p1_we    : p0_we;
    s_size  = sel ? p1_size  : p0_size;
    s_addr  = sel ? p1_addr  : p0_addr;
    s_wdata = sel ? p1_wdata : p0_wdata;
    accept  = rst_n && (state != HALF2) && (p0_req || p1_req);
    reject  = (s_size == 2'b11) ||
              ((s_size == SZ_HALF) && s_addr[0]) ||
              ((s_size == SZ_WORD) && (s_addr[1:0] != 2'b00)) ||
              (s_addr >= MEM_LIMIT);
  end

  // format the read response from the registered memory output
  always_comb begin
    case (resp_size)
      SZ_BYTE: resp_data = {24'b0, mem_read_data[7:0]};
      SZ_HALF: resp_data = {16'b0, mem_read_data[7:0], lo_q};
      default: resp_data = mem_read_data;
    endcase
  end

  // next state, grants, memory strobes and response routing; all zero in reset
  always_comb begin
    state_nxt      = IDLE;
    p0_gnt         = 1'b0;
    p1_gnt         = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_size       = 1'b0;
    mem_address    = 32'b0;
    mem_write_data = 32'b0;
    p0_rvalid      = 1'b0;
    p1_rvalid      = 1'b0;
    p0_rdata       = 32'b0;
    p1_rdata       = 32'b0;
    p0_err         = 1'b0;
    p1_err         = 1'b0;
    if (rst_n) begin
      p0_err = err_q[0];
      p1_err = err_q[1];
      if (state == RESP) begin
        if (resp_port) begin
          p1_rvalid = 1'b1;
          p1_rdata  = resp_data;
        end else begin
          p0_rvalid = 1'b1;
          p0_rdata  = resp_data;
        end
      end
      if (state == HALF2) begin
        mem_rd         = !h_we;
        mem_wr         = h_we;
        mem_address    = h_addr + 32'd1;
        mem_write_data = {24'b0, h_hi};
        state_nxt      = h_we ? IDLE : RESP;
      end else if (accept) begin
        p0_gnt = !sel;
        p1_gnt = sel;
        if (!reject) begin
          mem_rd         = !s_we;
          mem_wr         = s_we;
          mem_size       = (s_size == SZ_WORD);
          mem_address    = s_addr;
          mem_write_data = (s_size == SZ_HALF) ? {24'b0, s_wdata[7:0]} : s_wdata;
          if (s_size == SZ_HALF) begin
            state_nxt = HALF2;
          end else begin
            state_nxt = s_we ? IDLE : RESP;
          end
        end
      end
    end
  end

  // state register and one-cycle error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 2'b00;
    end else begin
      state <= state_nxt;
      err_q <= {accept && reject && sel, accept && reject && !sel};
    end
  end

  // capture half-access context and the owner of the pending read response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_port    <= 1'b0;
      h_we      <= 1'b0;
      h_addr    <= 32'b0;
      h_hi      <= 8'b0;
      lo_q      <= 8'b0;
      resp_port <= 1'b0;
      resp_size <= SZ_BYTE;
    end else begin
      if (accept && !reject && (s_size == SZ_HALF)) begin
        h_port <= sel;
        h_we   <= s_we;
        h_addr <= s_addr;
        h_hi   <= s_wdata[15:8];
      end
      if (accept && !reject && !s_we && (s_size != SZ_HALF)) begin
        resp_port <= sel;
        resp_size <= s_size;
      end
      if ((state == HALF2) && !h_we) begin
        lo_q      <= mem_read_data[7:0];
        resp_port <= h_port;
        resp_size <= SZ_HALF;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with directed and random traffic
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [1:0]  p0_size = 2'b0, p1_size = 2'b0;
  logic [31:0] p0_addr = 32'b0, p1_addr = 32'b0, p0_wdata = 32'b0, p1_wdata = 32'b0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_rd, mem_wr, mem_size;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_read_data = 32'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // stand-in for data_memory: byte array with registered read port
  logic [7:0] ram [MEM_BYTES];
  logic [9:0] ma;
  assign ma = mem_address[9:0];
  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_size) begin
        for (int k = 0; k < 4; k++) ram[ma + 10'(k)] <= mem_write_data[8*k +: 8];
      end else begin
        ram[ma] <= mem_write_data[7:0];
      end
    end
    if (mem_rd) begin
      mem_read_data <= mem_size ? {ram[ma + 10'd3], ram[ma + 10'd2], ram[ma + 10'd1], ram[ma]}
                                : {24'b0, ram[ma]};
    end
  end

  typedef struct { int code; logic [31:0] data; } exp_t;
  typedef struct { bit valid; bit we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } req_t;

  logic [7:0]  model_mem [MEM_BYTES];
  exp_t        sb_q[$];
  req_t        pend [2];
  int          waitc [2];
  int          total = 0;
  int          bad = 0;
  int          last_port = 1;
  bit          hb_busy = 0;
  bit          hb_we = 0;
  logic [31:0] hb_addr = 32'b0;
  logic [7:0]  hb_hi = 8'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(int p, bit we, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
    pend[p].valid = 1; pend[p].we = we; pend[p].size = size;
    pend[p].addr = addr; pend[p].wdata = wdata; waitc[p] = 0;
  endtask

  task automatic rand_req(int p);
    int r;
    logic [1:0] sz;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
    a = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
    end
    if ($urandom_range(0, 15) == 0) a = 32'(MEM_BYTES) + 32'($urandom_range(0, 4095));
    set_req(p, 1'($urandom_range(0, 1)), sz, a, $urandom);
  endtask

  // one clock of stimulus: drive, predict grant/memory command at posedge-1, update model
  task automatic cycle();
    int win, nb;
    bit e_rd, e_wr, e_sz, chk_wd, isbad;
    logic [31:0] e_addr, e_wd, wmask, d;
    req_t r;
    p0_req = pend[0].valid; p0_we = pend[0].we; p0_size = pend[0].size;
    p0_addr = pend[0].addr; p0_wdata = pend[0].wdata;
    p1_req = pend[1].valid; p1_we = pend[1].we; p1_size = pend[1].size;
    p1_addr = pend[1].addr; p1_wdata = pend[1].wdata;
    #4;
    win = -1; e_rd = 0; e_wr = 0; e_sz = 0; e_addr = 0; e_wd = 0; wmask = '1; chk_wd = 0;
    if (!rst_n) begin
      if (hb_busy && !hb_we) void'(sb_q.pop_back());
      hb_busy = 0; last_port = 1; chk_wd = 1;
    end else if (hb_busy) begin
      e_rd = !hb_we; e_wr = hb_we; e_addr = hb_addr + 1; e_wd = {24'b0, hb_hi};
      wmask = 32'hFF; chk_wd = hb_we; hb_busy = 0;
    end else if (pend[0].valid && pend[1].valid) begin
`ifdef DMEM_ARB_RR_EN
      win = (last_port == 1) ? 0 : 1;
`else
      win = 0;
`endif
    end else if (pend[0].valid) begin
      win = 0;
    end else if (pend[1].valid) begin
      win = 1;
    end
    if (win >= 0) begin
      r = pend[win];
      last_port = win;
      pend[win].valid = 0;
      isbad = (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) ||
              (r.size == 2'd2 && r.addr[1:0] != 2'b00) || (r.addr >= 32'(MEM_BYTES));
      if (isbad) begin
        sb_q.push_back('{win * 2 + 1, 32'h0});
      end else begin
        nb = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        e_rd = !r.we; e_wr = r.we; e_addr = r.addr; e_sz = (r.size == 2'd2);
        e_wd = r.wdata; wmask = (r.size == 2'd1) ? 32'hFF : '1; chk_wd = r.we;
        d = 0;
        for (int k = 0; k < nb; k++) begin
          if (r.we) model_mem[int'(r.addr) + k] = r.wdata[8*k +: 8];
          else d[8*k +: 8] = model_mem[int'(r.addr) + k];
        end
        if (!r.we) sb_q.push_back('{win * 2, d});
        if (r.size == 2'd1) begin
          hb_busy = 1; hb_we = r.we; hb_addr = r.addr; hb_hi = r.wdata[15:8];
        end
      end
    end
    chk("gnt", {30'b0, p1_gnt, p0_gnt}, (win == 0) ? 32'd1 : (win == 1) ? 32'd2 : 32'd0);
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    if (e_rd || e_wr || !rst_n) begin
      chk("mem_address", mem_address, e_addr);
      chk("mem_size", 32'(mem_size), 32'(e_sz));
    end
    if (chk_wd) chk("mem_write_data", mem_write_data & wmask, e_wd & wmask);
    for (int i = 0; i < 2; i++) begin
      if (pend[i].valid) begin
        waitc[i]++;
        if (waitc[i] > 200) begin
          bad++; total++;
          $display("FAIL grant timeout port %0d: got no gnt required gnt within 200 cycles", i);
          pend[i].valid = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (pend[0].valid || pend[1].valid); i++) cycle();
  endtask

  task automatic mon_port(int port, logic rv, logic [31:0] rd, logic er);
    exp_t e;
    if (rv || er) begin
      if (sb_q.size() == 0) begin
        bad++; total++;
        $display("FAIL unexpected response port %0d: got rvalid=%0b err=%0b required none", port, rv, er);
      end else begin
        e = sb_q.pop_front();
        chk("resp kind", 32'(port * 2 + (er ? 1 : 0)), 32'(e.code));
        if (rv && !er) chk("rdata", rd, e.data);
      end
    end else begin
      chk("rdata idle", rd, 32'h0);
    end
  endtask

  // response monitor, sampling mid-cycle before the driver moves inputs
  always @(posedge clk) begin
    #3;
    mon_port(0, p0_rvalid, p0_rdata, p0_err);
    mon_port(1, p1_rvalid, p1_rdata, p1_err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      ram[i] = 8'h0;
      model_mem[i] = 8'h0;
    end
    pend[0] = '{0, 0, 2'b0, 32'b0, 32'b0};
    pend[1] = '{0, 0, 2'b0, 32'b0, 32'b0};
    waitc[0] = 0; waitc[1] = 0;
    @(negedge clk);
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    set_req(0, 1, 2'd2, 32'h10, 32'hDEADBEEF); drain();
    set_req(0, 0, 2'd2, 32'h10, 32'h0); drain();
    repeat (2) cycle();

    set_req(1, 1, 2'd1, 32'h22, 32'h0000A5C3); cycle();
    set_req(0, 0, 2'd0, 32'h40, 32'h0); cycle();
    drain();
    set_req(1, 0, 2'd0, 32'h23, 32'h0); drain();
    set_req(1, 0, 2'd1, 32'h22, 32'h0); drain();
    repeat (3) cycle();

    set_req(0, 0, 2'd2, 32'h102, 32'h0); drain();
    set_req(0, 1, 2'd0, 32'h400, 32'h55); drain();
    set_req(1, 0, 2'd3, 32'h8, 32'h0); drain();
    repeat (2) cycle();

    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].valid) set_req(p, 0, 2'd0, 32'($urandom_range(0, 63)), 32'h0);
      end
      cycle();
    end
    drain();
    repeat (2) cycle();

    set_req(0, 0, 2'd1, 32'h22, 32'h0); cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    set_req(1, 0, 2'd0, 32'h23, 32'h0); cycle();
    drain();
    repeat (2) cycle();

    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].valid && $urandom_range(0, 1) == 1) rand_req(p);
      end
      cycle();
    end
    drain();
    repeat (4) cycle();
    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
